// File: rtl/bus_ctrl.sv
// Bus controller: decodes CPU address/port cycles into RAM, video, ROM,
// IO and open-bus regions, and inserts per-region wait states.
module bus_ctrl #(
    parameter int          RAM_BITS = 17,
    parameter logic [19:0] VID_BASE = 20'hB8000,
    parameter int          VID_BITS = 12,
    parameter logic [19:0] ROM_BASE = 20'hF0000,
    parameter int          ROM_BITS = 16,
    parameter logic [3:0]  RAM_WAIT = 4'd0,
    parameter logic [3:0]  VID_WAIT = 4'd1,
    parameter logic [3:0]  ROM_WAIT = 4'd1,
    parameter logic [3:0]  IO_WAIT  = 4'd2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [19:0]         cpu_address,
    input  logic [7:0]          cpu_out,
    input  logic                cpu_we,
    input  logic                cpu_pr,
    input  logic                cpu_pw,
    output logic [7:0]          cpu_in,
    output logic                cpu_ce,
    output logic [RAM_BITS-1:0] ram_a,
    input  logic [7:0]          ram_q,
    output logic                ram_w,
    output logic [VID_BITS-1:0] vid_a,
    input  logic [7:0]          vid_q,
    output logic                vid_w,
    output logic [ROM_BITS-1:0] rom_a,
    input  logic [7:0]          rom_q,
    output logic [15:0]         io_a,
    input  logic [7:0]          io_q,
    output logic                io_rd,
    output logic                io_wr,
    output logic [7:0]          mem_d,
    output logic [19:0]         open_addr,
    output logic                open_flag
);

    typedef enum logic [2:0] {
        REG_IO,
        REG_VID,
        REG_ROM,
        REG_RAM,
        REG_OPEN
    } region_t;

    // One past the last RAM byte; 21 bits so a full 1 MiB window still fits.
    localparam logic [20:0] RAM_LIMIT = 21'(1) << RAM_BITS;

    logic        w_io_req;
    logic        w_vid_hit;
    logic        w_rom_hit;
    logic        w_ram_hit;
    region_t     w_region;
    logic [3:0]  w_wait_sel;
    logic [7:0]  w_rdata;
    logic        w_ce;

    logic [3:0]  r_cnt;
    logic [19:0] r_open_addr;
    logic        r_open_flag;

    assign w_io_req  = cpu_pr | cpu_pw;
    assign w_vid_hit = (cpu_address[19:VID_BITS] == VID_BASE[19:VID_BITS]);
    assign w_rom_hit = (cpu_address[19:ROM_BITS] == ROM_BASE[19:ROM_BITS]);
    assign w_ram_hit = ({1'b0, cpu_address} < RAM_LIMIT);

    // Priority region decode: IO beats video beats ROM beats RAM.
    always_comb begin
        w_region = REG_OPEN;
        if (w_io_req) begin
            w_region = REG_IO;
        end else if (w_vid_hit) begin
            w_region = REG_VID;
        end else if (w_rom_hit) begin
            w_region = REG_ROM;
        end else if (w_ram_hit) begin
            w_region = REG_RAM;
        end
    end

    // Wait-state count and read-data source for the selected region.
    always_comb begin
        w_wait_sel = 4'd0;
        w_rdata    = 8'hFF;
        unique case (w_region)
            REG_IO: begin
                w_wait_sel = IO_WAIT;
                w_rdata    = io_q;
            end
            REG_VID: begin
                w_wait_sel = VID_WAIT;
                w_rdata    = vid_q;
            end
            REG_ROM: begin
                w_wait_sel = ROM_WAIT;
                w_rdata    = rom_q;
            end
            REG_RAM: begin
                w_wait_sel = RAM_WAIT;
                w_rdata    = ram_q;
            end
            default: begin
                w_wait_sel = 4'd0;
                w_rdata    = 8'hFF;
            end
        endcase
    end

    // Completion compares against the live wait_sel, so a region change
    // mid-wait takes effect at once; reset forces it low asynchronously.
    assign w_ce = reset_n & (r_cnt >= w_wait_sel);

    // Wait counter: clears on completion, otherwise counts elapsed cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if (w_ce) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Capture the address of completed open-bus cycles; flag stays set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_open_addr <= 20'd0;
            r_open_flag <= 1'b0;
        end else if (w_ce && (w_region == REG_OPEN)) begin
            r_open_addr <= cpu_address;
            r_open_flag <= 1'b1;
        end
    end

    assign cpu_ce    = w_ce;
    assign cpu_in    = w_rdata;
    assign mem_d     = cpu_out;

    assign ram_a     = cpu_address[RAM_BITS-1:0];
    assign vid_a     = cpu_address[VID_BITS-1:0];
    assign rom_a     = cpu_address[ROM_BITS-1:0];
    assign io_a      = cpu_address[15:0];

    // ROM has no write strobe: writes there are silently dropped.
    assign ram_w     = cpu_we & (w_region == REG_RAM) & w_ce;
    assign vid_w     = cpu_we & (w_region == REG_VID) & w_ce;

    // A simultaneous read and write request is a port write only.
    assign io_rd     = cpu_pr & ~cpu_pw & w_ce;
    assign io_wr     = cpu_pw & w_ce;

    assign open_addr = r_open_addr;
    assign open_flag = r_open_flag;

endmodule

// File: tb/tb_bus_ctrl.sv
// Testbench for bus_ctrl: directed vector table, hand-written corner
// sequences, then random accesses checked against a region-level model.
module tb_bus_ctrl;

    localparam int RAM_BITS = 17;
    localparam int VID_BASE = 32'hB8000;
    localparam int VID_BITS = 12;
    localparam int ROM_BASE = 32'hF0000;
    localparam int ROM_BITS = 16;

    logic                clock;
    logic                reset_n;
    logic [19:0]         cpu_address;
    logic [7:0]          cpu_out;
    logic                cpu_we;
    logic                cpu_pr;
    logic                cpu_pw;
    logic [7:0]          cpu_in;
    logic                cpu_ce;
    logic [RAM_BITS-1:0] ram_a;
    logic [7:0]          ram_q;
    logic                ram_w;
    logic [VID_BITS-1:0] vid_a;
    logic [7:0]          vid_q;
    logic                vid_w;
    logic [ROM_BITS-1:0] rom_a;
    logic [7:0]          rom_q;
    logic [15:0]         io_a;
    logic [7:0]          io_q;
    logic                io_rd;
    logic                io_wr;
    logic [7:0]          mem_d;
    logic [19:0]         open_addr;
    logic                open_flag;

    int n_cmp = 0;
    int n_err = 0;

    logic [19:0] exp_oaddr;
    logic        exp_oflag;

    bus_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_pr      (cpu_pr),
        .cpu_pw      (cpu_pw),
        .cpu_in      (cpu_in),
        .cpu_ce      (cpu_ce),
        .ram_a       (ram_a),
        .ram_q       (ram_q),
        .ram_w       (ram_w),
        .vid_a       (vid_a),
        .vid_q       (vid_q),
        .vid_w       (vid_w),
        .rom_a       (rom_a),
        .rom_q       (rom_q),
        .io_a        (io_a),
        .io_q        (io_q),
        .io_rd       (io_rd),
        .io_wr       (io_wr),
        .mem_d       (mem_d),
        .open_addr   (open_addr),
        .open_flag   (open_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [19:0] addr;
        logic        we;
        logic        pr;
        logic        pw;
        logic [7:0]  wd;
        int          lat;
        logic [7:0]  rd;
        logic        rw;
        logic        vw;
        logic        ir;
        logic        iw;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Region of an access, from plain address-window arithmetic.
    // 0=io 1=video 2=rom 3=ram 4=open
    function automatic int region_of(input logic [19:0] a,
                                     input logic pr, input logic pw);
        int ai;
        ai = int'(a);
        if (pr || pw) return 0;
        if (ai >= VID_BASE && ai < VID_BASE + (1 << VID_BITS)) return 1;
        if (ai >= ROM_BASE && ai < ROM_BASE + (1 << ROM_BITS)) return 2;
        if (ai < (1 << RAM_BITS)) return 3;
        return 4;
    endfunction

    function automatic int wait_of(input int r);
        case (r)
            0: return 2;
            1: return 1;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    // Run one access from a cycle boundary with cnt at 0; checks every
    // cycle until the expected completion, then the open-bus registers.
    task automatic access(input string tag, input logic [19:0] a,
                          input logic we, input logic pr, input logic pw,
                          input logic [7:0] wd, input int lat,
                          input logic [7:0] rd, input logic rw,
                          input logic vw, input logic ir, input logic iw);
        bit last;
        cpu_address = a;
        cpu_we      = we;
        cpu_pr      = pr;
        cpu_pw      = pw;
        cpu_out     = wd;
        for (int k = 0; k < lat; k++) begin
            @(negedge clock);
            last = (k == lat - 1);
            chk({tag, " ce"}, 32'(cpu_ce), 32'(last));
            chk({tag, " ram_w"}, 32'(ram_w), 32'(rw & last));
            chk({tag, " vid_w"}, 32'(vid_w), 32'(vw & last));
            chk({tag, " io_rd"}, 32'(io_rd), 32'(ir & last));
            chk({tag, " io_wr"}, 32'(io_wr), 32'(iw & last));
            if (last) begin
                chk({tag, " cpu_in"}, 32'(cpu_in), 32'(rd));
                chk({tag, " mem_d"}, 32'(mem_d), 32'(wd));
                chk({tag, " ram_a"}, 32'(ram_a),
                    32'(a) % (1 << RAM_BITS));
                chk({tag, " vid_a"}, 32'(vid_a),
                    32'(a) % (1 << VID_BITS));
                chk({tag, " rom_a"}, 32'(rom_a),
                    32'(a) % (1 << ROM_BITS));
                chk({tag, " io_a"}, 32'(io_a), 32'(a) % 65536);
            end
            @(posedge clock);
            #1;
        end
        if (region_of(a, pr, pw) == 4) begin
            exp_oaddr = a;
            exp_oflag = 1'b1;
        end
        chk({tag, " open_addr"}, 32'(open_addr), 32'(exp_oaddr));
        chk({tag, " open_flag"}, 32'(open_flag), 32'(exp_oflag));
    endtask

    vec_t vecs[14];

    initial begin
        logic [19:0] a;
        logic        we;
        logic        pr;
        logic        pw;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          r;
        int          pick;

        // Directed vectors: fixed read data per target.
        vecs[0]  = '{20'h01234, 1, 0, 0, 8'h5A, 1, 8'h11, 1, 0, 0, 0};
        vecs[1]  = '{20'hB8010, 0, 0, 0, 8'h00, 2, 8'h41, 0, 0, 0, 0};
        vecs[2]  = '{20'h003D4, 0, 0, 1, 8'h0E, 3, 8'h33, 0, 0, 0, 1};
        vecs[3]  = '{20'hF0100, 1, 0, 0, 8'hC3, 2, 8'h22, 0, 0, 0, 0};
        vecs[4]  = '{20'h50000, 0, 0, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 0};
        vecs[5]  = '{20'h00060, 0, 1, 0, 8'h00, 3, 8'h33, 0, 0, 1, 0};
        vecs[6]  = '{20'h00061, 0, 1, 1, 8'h77, 3, 8'h33, 0, 0, 0, 1};
        vecs[7]  = '{20'hB8FFF, 1, 0, 0, 8'h99, 2, 8'h41, 0, 1, 0, 0};
        vecs[8]  = '{20'hB9000, 1, 0, 0, 8'h12, 1, 8'hFF, 0, 0, 0, 0};
        vecs[9]  = '{20'h1FFFF, 0, 0, 0, 8'h00, 1, 8'h11, 0, 0, 0, 0};
        vecs[10] = '{20'h20000, 1, 0, 0, 8'h34, 1, 8'hFF, 0, 0, 0, 0};
        vecs[11] = '{20'hFFFFF, 0, 0, 0, 8'h00, 2, 8'h22, 0, 0, 0, 0};
        vecs[12] = '{20'hB8000, 1, 1, 0, 8'h56, 3, 8'h33, 0, 0, 1, 0};
        vecs[13] = '{20'hB7FFF, 0, 0, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 0};

        ram_q = 8'h11;
        vid_q = 8'h41;
        rom_q = 8'h22;
        io_q  = 8'h33;
        exp_oaddr = 20'd0;
        exp_oflag = 1'b0;

        // Reset state, with a zero-wait RAM write pending.
        reset_n     = 1'b0;
        cpu_address = 20'h01234;
        cpu_we      = 1'b1;
        cpu_pr      = 1'b0;
        cpu_pw      = 1'b0;
        cpu_out     = 8'h5A;
        #3;
        chk("rst ce", 32'(cpu_ce), 32'd0);
        chk("rst ram_w", 32'(ram_w), 32'd0);
        chk("rst open_addr", 32'(open_addr), 32'd0);
        chk("rst open_flag", 32'(open_flag), 32'd0);
        repeat (3) @(posedge clock);
        chk("rst hold ce", 32'(cpu_ce), 32'd0);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we,
                   vecs[i].pr, vecs[i].pw, vecs[i].wd, vecs[i].lat,
                   vecs[i].rd, vecs[i].rw, vecs[i].vw, vecs[i].ir,
                   vecs[i].iw);
        end

        // Open-bus capture is held across non-open accesses.
        access("hold", 20'h00010, 0, 0, 0, 8'h00, 1, 8'h11, 0, 0, 0, 0);
        chk("hold open_addr", 32'(open_addr), 32'hB7FFF);

        // Region change mid-wait: IO (2 waits) becomes RAM (0 waits)
        // with cnt already at 1, so it completes at once.
        cpu_address = 20'h00060;
        cpu_we      = 1'b0;
        cpu_pr      = 1'b1;
        cpu_pw      = 1'b0;
        @(negedge clock);
        chk("swap1 ce0", 32'(cpu_ce), 32'd0);
        @(posedge clock);
        #1;
        cpu_pr      = 1'b0;
        cpu_address = 20'h00100;
        @(negedge clock);
        chk("swap1 ce", 32'(cpu_ce), 32'd1);
        chk("swap1 io_rd", 32'(io_rd), 32'd0);
        chk("swap1 cpu_in", 32'(cpu_in), 32'h11);
        @(posedge clock);
        #1;

        // ROM (1 wait) becomes IO write (2 waits) at cnt 1: one more cycle.
        cpu_address = 20'hF0010;
        @(negedge clock);
        chk("swap2 ce0", 32'(cpu_ce), 32'd0);
        @(posedge clock);
        #1;
        cpu_pw      = 1'b1;
        cpu_address = 20'h00080;
        @(negedge clock);
        chk("swap2 ce1", 32'(cpu_ce), 32'd0);
        chk("swap2 io_wr1", 32'(io_wr), 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("swap2 ce2", 32'(cpu_ce), 32'd1);
        chk("swap2 io_wr2", 32'(io_wr), 32'd1);
        @(posedge clock);
        #1;
        cpu_pw = 1'b0;

        // Reset during an IO write wait at cnt 1 aborts it immediately.
        cpu_address = 20'h003D4;
        cpu_pw      = 1'b1;
        cpu_out     = 8'h0E;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort ce", 32'(cpu_ce), 32'd0);
        chk("abort io_wr", 32'(io_wr), 32'd0);
        chk("abort open_flag", 32'(open_flag), 32'd0);
        chk("abort open_addr", 32'(open_addr), 32'd0);
        exp_oaddr = 20'd0;
        exp_oflag = 1'b0;
        @(negedge clock);
        chk("abort io_wr hold", 32'(io_wr), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        access("restart", 20'h003D4, 0, 0, 1, 8'h0E, 3, 8'h33,
               0, 0, 0, 1);

        // Random accesses against the region model.
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 5);
            we = 1'($urandom_range(0, 1));
            pr = 1'b0;
            pw = 1'b0;
            case (pick)
                0: a = 20'($urandom_range(0, (1 << RAM_BITS) - 1));
                1: a = 20'(VID_BASE + $urandom_range(0, 4095));
                2: a = 20'(ROM_BASE + $urandom_range(0, 65535));
                3: a = 20'($urandom);
                4: begin
                    a  = 20'($urandom);
                    pr = 1'($urandom_range(0, 1));
                    pw = ~pr | 1'($urandom_range(0, 1));
                end
                default: begin
                    case ($urandom_range(0, 5))
                        0: a = 20'hB7FFF;
                        1: a = 20'hB9000;
                        2: a = 20'h1FFFF;
                        3: a = 20'h20000;
                        4: a = 20'hEFFFF;
                        default: a = 20'hB8000;
                    endcase
                end
            endcase
            wd    = 8'($urandom);
            ram_q = 8'($urandom);
            vid_q = 8'($urandom);
            rom_q = 8'($urandom);
            io_q  = 8'($urandom);
            r = region_of(a, pr, pw);
            case (r)
                0: rd = io_q;
                1: rd = vid_q;
                2: rd = rom_q;
                3: rd = ram_q;
                default: rd = 8'hFF;
            endcase
            access($sformatf("rnd%0d", n), a, we, pr, pw, wd,
                   wait_of(r) + 1, rd,
                   we & (r == 3), we & (r == 1), pr & ~pw, pw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
